// File: rtl/spi_router_nport.sv
// spi_router_nport: SPI-slave receiver that routes {dest, data[, parity]} frames into per-port FIFOs.
// Latency: port head valid 2 core cycles after the cycle that detects the last serial clock edge.
// Backpressure: per-port valid/ready; a frame to a full, non-popping port is dropped and flagged. Option macro: ROUTER_PARITY_EN.

module spi_router_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int AW = $clog2(D);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(D);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          push, pop;

    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld & rd_rdy;
    // A full FIFO still takes a write when its head leaves in the same cycle.
    assign wr_rdy = (cnt != FULL_CNT) | pop;
    assign push   = wr_vld & wr_rdy;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < D; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

module spi_router_nport #(
    parameter int WIDTH = 8,
    parameter int PORTS = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   masterClock,
    input  logic                   chipSelectN,
    input  logic                   bitIn,
    input  logic [PORTS-1:0]       portReady,
    output logic [PORTS-1:0]       portValid,
    output logic [PORTS*WIDTH-1:0] portData,
    output logic [PORTS-1:0]       overflow,
    output logic                   error,
    output logic [7:0]             errorCount
);
    localparam int PA = $clog2(PORTS);
`ifdef ROUTER_PARITY_EN
    localparam int FLEN = PA + WIDTH + 1;
`else
    localparam int FLEN = PA + WIDTH;
`endif
    localparam int BCW = $clog2(FLEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    state_t state, state_nxt;

    logic [1:0]       sck_sync, cs_sync, din_sync;
    logic             sck_d, cs_d;
    logic             sck_rise, cs_low, cs_fall;
    logic [BCW-1:0]   bit_cnt;
    logic [FLEN-1:0]  frame;
    logic             shift_en, cnt_clr, check_en;
    logic [PA-1:0]    dest;
    logic [WIDTH-1:0] data;
    logic             par_ok, accept, reject;
    logic [PORTS-1:0] push_req, wr_rdy, drop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_sync <= '0;
            cs_sync  <= '0;
            din_sync <= '0;
            sck_d    <= 1'b0;
            cs_d     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], masterClock};
            cs_sync  <= {cs_sync[0], chipSelectN};
            din_sync <= {din_sync[0], bitIn};
            sck_d    <= sck_sync[1];
            cs_d     <= cs_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign cs_low   = ~cs_sync[1];
    // Synchronisers clear low, so a select held low across reset never looks like a fresh falling edge.
    assign cs_fall  = cs_d & ~cs_sync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        check_en  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (cs_fall) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!cs_low) begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BCW'(FLEN - 1)) state_nxt = CHECK;
                end
            end
            CHECK: begin
                check_en  = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = cs_low ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            frame   <= '0;
        end else begin
            if (cnt_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + BCW'(1);
            if (shift_en)      frame   <= {frame[FLEN-2:0], din_sync[1]};
        end
    end

    assign dest = frame[FLEN-1 -: PA];
    assign data = frame[FLEN-1-PA -: WIDTH];

`ifdef ROUTER_PARITY_EN
    // Even parity: the trailing bit makes the ones count over the whole frame even.
    assign par_ok = ~^frame;
`else
    assign par_ok = 1'b1;
`endif

    assign accept = check_en & par_ok;
    assign reject = check_en & ~par_ok;

    genvar p;
    generate
        for (p = 0; p < PORTS; p++) begin : g_port
            logic             fifo_vld;
            logic [WIDTH-1:0] fifo_dat, last_dat;

            assign push_req[p] = accept && (dest == PA'(p));

            spi_router_fifo #(.W(WIDTH), .D(DEPTH)) u_fifo (
                .core_clk (clock),
                .arst_n   (reset),
                .wr_vld   (push_req[p]),
                .wr_dat   (data),
                .wr_rdy   (wr_rdy[p]),
                .rd_vld   (fifo_vld),
                .rd_dat   (fifo_dat),
                .rd_rdy   (portReady[p])
            );

            // Holds the most recently popped word so an empty port keeps showing it.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)                         last_dat <= '0;
                else if (fifo_vld && portReady[p])  last_dat <= fifo_dat;
            end

            assign drop[p]                     = push_req[p] & ~wr_rdy[p];
            assign portValid[p]                = fifo_vld;
            assign portData[p*WIDTH +: WIDTH]  = fifo_vld ? fifo_dat : last_dat;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow   <= '0;
            error      <= 1'b0;
            errorCount <= '0;
        end else begin
            overflow <= overflow | drop;
            error    <= reject;
            if (reject && errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_spi_router_nport.sv
// Randomised bench for spi_router_nport against a queue-based model of routing, overflow and error counting.
`timescale 1ns/1ps
module tb_spi_router_nport;
    localparam int WIDTH = 8;
    localparam int PORTS = 4;
    localparam int DEPTH = 4;
    localparam int PA    = 2;
`ifdef ROUTER_PARITY_EN
    localparam int FLEN  = PA + WIDTH + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FLEN  = PA + WIDTH;
    localparam bit PAR   = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   masterClock = 1'b0;
    logic                   chipSelectN = 1'b1;
    logic                   bitIn = 1'b0;
    logic [PORTS-1:0]       portReady = '0;
    logic [PORTS-1:0]       portValid;
    logic [PORTS*WIDTH-1:0] portData;
    logic [PORTS-1:0]       overflow;
    logic                   error;
    logic [7:0]             errorCount;

    spi_router_nport #(.WIDTH(WIDTH), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .masterClock (masterClock),
        .chipSelectN (chipSelectN),
        .bitIn       (bitIn),
        .portReady   (portReady),
        .portValid   (portValid),
        .portData    (portData),
        .overflow    (overflow),
        .error       (error),
        .errorCount  (errorCount)
    );

    always #5 clock = ~clock;

    logic [WIDTH-1:0] mq [PORTS][$];
    logic [WIDTH-1:0] last_pop [PORTS];
    logic [PORTS-1:0] m_ovf;
    int               m_err;
    int               checks = 0;
    int               fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [PORTS-1:0] exp_valid();
        logic [PORTS-1:0] v;
        for (int p = 0; p < PORTS; p++) v[p] = (mq[p].size() != 0);
        return v;
    endfunction

    function automatic logic [PORTS*WIDTH-1:0] exp_data();
        logic [PORTS*WIDTH-1:0] v;
        for (int p = 0; p < PORTS; p++)
            v[p*WIDTH +: WIDTH] = (mq[p].size() != 0) ? mq[p][0] : last_pop[p];
        return v;
    endfunction

    task automatic check_all(input string where);
        check({where, "/valid"},  portValid,  exp_valid());
        check({where, "/data"},   portData,   exp_data());
        check({where, "/ovf"},    overflow,   m_ovf);
        check({where, "/errcnt"}, errorCount, 64'(m_err > 255 ? 255 : m_err));
    endtask

    task automatic model_clear();
        for (int p = 0; p < PORTS; p++) begin
            mq[p].delete();
            last_pop[p] = '0;
        end
        m_ovf = '0;
        m_err = 0;
    endtask

    // Sends the first nbits of a frame; a full frame also checks exact output timing around the final edge.
    task automatic send_frame(input logic [PA-1:0] dest, input logic [WIDTH-1:0] data, input int nbits,
                              input bit bad, input bit same_pop, input bit keep_cs);
        logic [FLEN-1:0] fr;
        bit full, rej, was_empty;
        int p;
        p    = int'(dest);
        full = (nbits == FLEN);
        rej  = full && PAR && bad;
`ifdef ROUTER_PARITY_EN
        fr = {dest, data, (^{dest, data}) ^ bad};
`else
        fr = {dest, data};
`endif
        @(negedge clock);
        if (chipSelectN) begin
            chipSelectN = 1'b0;
            repeat (4) @(negedge clock);
        end
        for (int i = 0; i < nbits; i++) begin
            bitIn = fr[FLEN-1-i];
            repeat (2) @(negedge clock);
            masterClock = 1'b1;
            if (full && i == FLEN - 1) begin
                was_empty = (mq[p].size() == 0);
                repeat (3) @(posedge clock);
                #1;
                if (same_pop) portReady[p] = 1'b1;
                check("err_before", error, 0);
                if (was_empty) check("vld_before", portValid[p], 0);
                @(posedge clock);
                #1;
                if (same_pop) portReady[p] = 1'b0;
                if (same_pop && mq[p].size() != 0) last_pop[p] = mq[p].pop_front();
                if (rej) m_err++;
                else if (mq[p].size() < DEPTH) mq[p].push_back(data);
                else m_ovf[p] = 1'b1;
                check("err_pulse", error, rej);
                check("vld_lat2", portValid[p], mq[p].size() != 0);
                @(posedge clock);
                #1;
                check("err_clear", error, 0);
                @(negedge clock);
            end else begin
                repeat (3) @(negedge clock);
            end
            masterClock = 1'b0;
            repeat (2) @(negedge clock);
        end
        if (!keep_cs) begin
            chipSelectN = 1'b1;
            repeat (4) @(negedge clock);
        end
    endtask

    task automatic pop_word(input int p);
        @(negedge clock);
        portReady[p] = 1'b1;
        @(negedge clock);
        portReady[p] = 1'b0;
        last_pop[p] = mq[p].pop_front();
        check_all("pop");
    endtask

    task automatic drain_all();
        for (int p = 0; p < PORTS; p++)
            while (mq[p].size() != 0) pop_word(p);
    endtask

    initial begin
        model_clear();
        #1 reset = 1'b0;
        #1;
        check_all("reset");
        check("reset/error", error, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        send_frame(2'd2, 8'hA5, FLEN, 1'b0, 1'b0, 1'b0);
        check_all("a5_to_p2");
        check("a5_slice", portData[23:16], 8'hA5);

        send_frame(2'd1, 8'h3C, FLEN, 1'b1, 1'b0, 1'b0);
        check_all("bad_parity");

        send_frame(2'd0, 8'hFF, 6, 1'b0, 1'b0, 1'b0);
        check_all("abort6");
        send_frame(2'd3, 8'h01, FLEN, 1'b0, 1'b0, 1'b0);
        check_all("after_abort");
        drain_all();

        for (int i = 0; i < DEPTH; i++) send_frame(2'd0, 8'(8'h50 + i), FLEN, 1'b0, 1'b0, 1'b0);
        send_frame(2'd0, 8'hAA, FLEN, 1'b0, 1'b1, 1'b0);
        check_all("same_cycle_pop");
        check("same_cycle_ovf0", overflow[0], 0);
        drain_all();

        for (int i = 0; i < 5; i++) send_frame(2'd0, 8'(8'h10 + i), FLEN, 1'b0, 1'b0, 1'b0);
        check_all("fill5");
        check("fill5_ovf0", overflow[0], 1);
        drain_all();
        check("drained_vld0", portValid[0], 0);

        for (int n = 0; n < 40; n++) begin
            int r, p;
            r = $urandom_range(0, 9);
            p = $urandom_range(0, PORTS - 1);
            if (r < 2 && mq[p].size() != 0) begin
                pop_word(p);
            end else if (r == 2) begin
                send_frame(PA'(p), 8'($urandom), $urandom_range(1, FLEN - 1), 1'b0, 1'b0, 1'b0);
                check_all("rnd_abort");
            end else begin
                send_frame(PA'(p), 8'($urandom), FLEN, ($urandom_range(0, 3) == 0),
                           1'b0, ($urandom_range(0, 3) == 0));
                check_all("rnd_frame");
            end
        end
        if (!chipSelectN) begin
            @(negedge clock);
            chipSelectN = 1'b1;
            repeat (4) @(negedge clock);
        end

        send_frame(2'd1, 8'h77, FLEN, 1'b0, 1'b0, 1'b0);
        send_frame(2'd2, 8'h12, 5, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_valid", portValid, 0);
        check("rst_data", portData, 0);
        check("rst_ovf", overflow, 0);
        check("rst_error", error, 0);
        check("rst_errcnt", errorCount, 0);
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < FLEN + 2; i++) begin
            bitIn = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clock);
            masterClock = 1'b1;
            repeat (3) @(negedge clock);
            masterClock = 1'b0;
            repeat (2) @(negedge clock);
        end
        repeat (6) @(negedge clock);
        check_all("held_cs_after_reset");
        chipSelectN = 1'b1;
        repeat (4) @(negedge clock);
        send_frame(2'd3, 8'hC3, FLEN, 1'b0, 1'b0, 1'b0);
        check_all("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
